// File: rtl/uart_tx_sched_if.sv
// Bus between the TX scheduler, its source FIFO and the UART transmitter.
// master: scheduler side; slave: FIFO/UART side.
interface uart_tx_sched_if #(
  parameter int unsigned USEDW_W = 8
);
  logic               fifo_empty;
  logic [USEDW_W-1:0] fifo_usedw;
  logic [7:0]         fifo_rd_data;
  logic               fifo_rd_req;
  logic               tx_busy;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               sched_busy;

  modport master (
    input  fifo_empty, fifo_usedw, fifo_rd_data, tx_busy,
    output fifo_rd_req, tx_start, tx_data, sched_busy
  );

  modport slave (
    output fifo_empty, fifo_usedw, fifo_rd_data, tx_busy,
    input  fifo_rd_req, tx_start, tx_data, sched_busy
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: pulls bytes from a FIFO in bursts of up to PKT_LEN and hands
// them one at a time to a UART transmitter.
// Optional feature: define UART_TX_SCHED_TIMEOUT_EN to flush partial bursts
// after TIMEOUT_CYC idle cycles; without it only full bursts are sent.
module uart_tx_sched #(
  parameter int unsigned PKT_LEN     = 4,
  parameter int unsigned TIMEOUT_CYC = 52080,
  parameter int unsigned USEDW_W     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_sched_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  // Reject parameter values that have no meaning for this block.
  if (PKT_LEN < 1 || PKT_LEN > 255 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_tx_sched: PKT_LEN must be 1..255 and TIMEOUT_CYC >= 1");
  end

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [1:0]         ack_q, ack_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [USEDW_W-1:0] usedw;
  logic [31:0]        usedw_ext;
  logic               full;
  logic               flush;

  assign usedw     = bus.fifo_usedw;
  assign usedw_ext = 32'(usedw);
  assign full      = (usedw_ext >= PKT_LEN);

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned        TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]    TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_q, to_d;

  // Idle-time counter: runs only while a partial burst waits in IDLE.
  always_comb begin
    to_d = to_q;
    if (state_q != IDLE || bus.fifo_empty || full) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + TO_W'(1);
    end
  end

  // Idle-time counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end

  assign flush = (to_q == TO_MAX) && !bus.fifo_empty;
`else
  assign flush = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst count, lost-ack counter and held transmit byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: begin
        // A full burst wins over a simultaneous timeout flush.
        if (!bus.tx_busy && (full || flush)) begin
          state_d = RD;
          cnt_d   = full ? 8'(PKT_LEN) : 8'(usedw_ext);
        end
      end
      RD: begin
        state_d = bus.fifo_empty ? IDLE : LAT;
      end
      LAT: begin
        tx_data_d = bus.fifo_rd_data;
        state_d   = LAUNCH;
      end
      LAUNCH: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_busy || ack_q == 2'd3) begin
          state_d = WAIT_DONE;
        end else begin
          ack_d = ack_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1 || bus.fifo_empty) ? IDLE : RD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.fifo_rd_req = (state_q == RD) && !bus.fifo_empty;
    bus.tx_start    = (state_q == LAUNCH);
    bus.sched_busy  = (state_q != IDLE);
    bus.tx_data     = tx_data_q;
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: FIFO and UART behavioural models, a byte-order
// scoreboard and per-cycle protocol checks, driven by directed scenarios.
module tb_uart_tx_sched;
  localparam int unsigned PKT   = 4;
  localparam int unsigned TO    = 60;
  localparam int unsigned FRAME = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.USEDW_W(8)) bus ();

  uart_tx_sched #(
    .PKT_LEN    (PKT),
    .TIMEOUT_CYC(TO),
    .USEDW_W    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: one-cycle read latency, not affected by the scheduler reset.
  logic [7:0]  mem [0:255];
  int unsigned wr_ptr = 0, rd_ptr = 0;
  logic        wr_en  = 1'b0;
  logic [7:0]  wr_dat = '0;
  logic [7:0]  rd_data = '0;
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[7:0]] <= wr_dat;
      wr_ptr <= wr_ptr + 1;
    end
    if (bus.fifo_rd_req && wr_ptr != rd_ptr) begin
      rd_data <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end
  assign bus.fifo_empty   = (wr_ptr == rd_ptr);
  assign bus.fifo_usedw   = 8'(wr_ptr - rd_ptr);
  assign bus.fifo_rd_data = rd_data;

  // UART model: busy for FRAME cycles starting the cycle after tx_start.
  logic        noack = 1'b0;
  logic        uart_busy = 1'b0;
  int unsigned busy_cnt = 0;
  always @(posedge clk) begin
    if (bus.tx_start && !noack) begin
      uart_busy <= 1'b1;
      busy_cnt  <= FRAME;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt  <= 0;
      uart_busy <= 1'b0;
    end
  end
  assign bus.tx_busy = uart_busy;

  // Scoreboard state: bytes written and not yet transmitted, in write order.
  logic [7:0]  exp_q[$];
  logic [7:0]  sent_log[$];
  int unsigned burst_log[$];
  int unsigned start_cyc[$];
  int unsigned n_starts   = 0;
  int unsigned burst_cur  = 0;
  int unsigned last_start = 0;
  logic        have_data  = 1'b0;
  logic        prev_sb    = 1'b0;
  logic [7:0]  held       = '0;

  // Compare process: protocol invariants and byte order on every cycle.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      burst_cur = 0;
      have_data = 1'b0;
      prev_sb   = 1'b0;
    end else begin
      if (bus.fifo_rd_req) chk("rd_req_while_empty", 32'(bus.fifo_empty), 32'd0);
      if (bus.tx_start) begin
        if (exp_q.size() == 0) begin
          chk("tx_without_pending_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte_order", 32'(bus.tx_data), 32'(e));
        end
        if (burst_cur > 0) begin
          if (noack) chk("lost_ack_spacing", cyc - last_start, 32'd8);
          else       chk("tx_start_spacing", cyc - last_start, FRAME + 4);
        end
        sent_log.push_back(bus.tx_data);
        start_cyc.push_back(cyc);
        last_start = cyc;
        burst_cur++;
        n_starts++;
        held      = bus.tx_data;
        have_data = 1'b1;
      end else if (have_data) begin
        chk("tx_data_stable", 32'(bus.tx_data), 32'(held));
      end
      if (prev_sb && !bus.sched_busy) begin
        burst_log.push_back(burst_cur);
        burst_cur = 0;
      end
      prev_sb = bus.sched_busy;
    end
  end

  task automatic push_byte(input logic [7:0] d);
    wr_en  = 1'b1;
    wr_dat = d;
    exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_starts(input int unsigned target, input string name);
    int unsigned k = 0;
    while ((n_starts < target || bus.sched_busy || uart_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk(name, n_starts, target);
  endtask

  task automatic clear_logs();
    sent_log.delete();
    burst_log.delete();
    start_cyc.delete();
  endtask

  task automatic check_bursts(input string name, input int unsigned b0, input int unsigned b1,
                              input int unsigned b2, input int unsigned n);
    int unsigned exp_b[3];
    exp_b = '{b0, b1, b2};
    chk({name, "_count"}, burst_log.size(), n);
    for (int i = 0; i < int'(n) && i < burst_log.size(); i++)
      chk($sformatf("%s_len%0d", name, i), burst_log[i], exp_b[i]);
  endtask

  task automatic check_sent(input string name, input logic [7:0] v[$]);
    chk({name, "_count"}, sent_log.size(), v.size());
    for (int i = 0; i < v.size() && i < sent_log.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), 32'(sent_log[i]), 32'(v[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned w2;
    logic [7:0]  v[$];

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_rd_req", 32'(bus.fifo_rd_req), 32'd0);
    chk("reset_tx_start", 32'(bus.tx_start), 32'd0);
    chk("reset_tx_data", 32'(bus.tx_data), 32'h00);
    chk("reset_sched_busy", 32'(bus.sched_busy), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Full burst of four in FIFO order
    clear_logs();
    push_byte(8'hA5); push_byte(8'h3C); push_byte(8'hFF); push_byte(8'h00);
    wait_starts(4, "full_burst_done");
    chk("full_burst_idle", 32'(bus.sched_busy), 32'd0);
    v = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    check_sent("full_burst", v);
    check_bursts("full_burst", 4, 0, 0, 1);

    // Two-byte partial burst
    clear_logs();
    base = n_starts;
    push_byte(8'h11);
    w2 = cyc;
    push_byte(8'h22);
`ifdef UART_TX_SCHED_TIMEOUT_EN
    wait_starts(base + 2, "partial_flush_done");
    if (start_cyc.size() > 0) chk("partial_flush_delay", start_cyc[0] - w2, TO + 2);
    else chk("partial_flush_delay_seen", 32'(start_cyc.size()), 32'd1);
    v = '{8'h11, 8'h22};
    check_sent("partial", v);
    check_bursts("partial", 2, 0, 0, 1);
`else
    repeat (5 * TO) @(negedge clk);
    chk("no_partial_flush", n_starts, base);
    push_byte(8'h33); push_byte(8'h44);
    wait_starts(base + 4, "partial_completed_done");
    v = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_sent("partial", v);
    check_bursts("partial", 4, 0, 0, 1);
`endif

    // Nine bytes: bursts are capped at PKT_LEN, later writes do not extend them
    clear_logs();
    base = n_starts;
    for (int unsigned i = 0; i < 9; i++) push_byte(8'(8'h50 + i));
`ifdef UART_TX_SCHED_TIMEOUT_EN
    wait_starts(base + 9, "nine_done");
    check_bursts("nine", 4, 4, 1, 3);
`else
    wait_starts(base + 8, "nine_full_done");
    repeat (3 * TO) @(negedge clk);
    chk("nine_leftover_held", n_starts, base + 8);
    for (int unsigned i = 9; i < 12; i++) push_byte(8'(8'h50 + i));
    wait_starts(base + 12, "nine_drain_done");
    check_bursts("nine", 4, 4, 4, 3);
`endif

    // Reset during WAIT_DONE of the second byte
    clear_logs();
    base = n_starts;
    push_byte(8'h5A); push_byte(8'h6B); push_byte(8'h7C);
    push_byte(8'h8D); push_byte(8'h9E); push_byte(8'hAF);
    for (int k = 0; k < 500 && n_starts < base + 2; k++) @(negedge clk);
    chk("pre_reset_two_sent", n_starts, base + 2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rd_req", 32'(bus.fifo_rd_req), 32'd0);
    chk("midreset_tx_start", 32'(bus.tx_start), 32'd0);
    chk("midreset_tx_data", 32'(bus.tx_data), 32'h00);
    chk("midreset_sched_busy", 32'(bus.sched_busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("held_reset_sched_busy", 32'(bus.sched_busy), 32'd0);
    burst_log.delete();
    #2 rst_n = 1'b1;
    @(negedge clk);
    wait_starts(base + 6, "after_reset_done");
    v = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF};
    check_sent("reset_resume", v);
    check_bursts("reset_resume", 4, 0, 0, 1);

    // UART never acknowledges: lost-ack guard paces the burst
    clear_logs();
    base  = n_starts;
    noack = 1'b1;
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
    wait_starts(base + 4, "lost_ack_done");
    if (start_cyc.size() == 4) chk("lost_ack_total_span", start_cyc[3] - start_cyc[0], 32'd24);
    else chk("lost_ack_start_count", 32'(start_cyc.size()), 32'd4);
    check_bursts("lost_ack", 4, 0, 0, 1);
    noack = 1'b0;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("fifo_drained", 32'(bus.fifo_empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter PKT_LEN, default 4: bytes that make up one full burst (range 1..255).
REQ-002 Parameter TIMEOUT_CYC, default 52080: idle cycles before a partial burst is flushed (10 bit times at 9600 baud, 50 MHz).
REQ-003 Parameter USEDW_W, default 8: width of the FIFO fill count.
REQ-004 Port clk  input  1  system clock, 50 MHz.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port fifo_empty  input  1  FIFO empty flag.
REQ-007 Port fifo_usedw  input  USEDW_W  FIFO fill count.
REQ-008 Port fifo_rd_data  input  8  FIFO read data, valid one cycle after fifo_rd_req.
REQ-009 Port fifo_rd_req  output  1  FIFO read strobe, one cycle per byte.
REQ-010 Port tx_busy  input  1  UART transmitter busy; rises the cycle after tx_start and stays high until the stop bit ends.
REQ-011 Port tx_start  output  1  one-cycle request to the UART transmitter to send tx_data.
REQ-012 Port tx_data  output  8  byte to transmit; held stable from tx_start until the next tx_start.
REQ-013 Port sched_busy  output  1  high while a burst is in progress (any state other than IDLE).

Function
REQ-014 States SHALL be IDLE, RD, LAT, LAUNCH, WAIT_ACK and WAIT_DONE, one-hot or binary.
REQ-015 IDLE -> RD SHALL occur when tx_busy=0 and either fifo_usedw>=PKT_LEN, or the timeout has expired and fifo_empty=0.
REQ-016 On leaving IDLE, the remaining-burst count SHALL load min(fifo_usedw, PKT_LEN).
REQ-017 RD: fifo_rd_req=1 for exactly one cycle, then go to LAT.
REQ-018 LAT: one cycle that absorbs the FIFO read latency; tx_data SHALL register fifo_rd_data at the end of LAT.
REQ-019 LAUNCH: tx_start=1 for exactly one cycle, then go to WAIT_ACK.
REQ-020 WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE; if tx_busy is not seen within 4 cycles, go to WAIT_DONE anyway (lost-ack guard).
REQ-021 WAIT_DONE: on tx_busy=0, decrement the remaining count.
REQ-022 After the decrement: if the count is 0 or fifo_empty=1, go to IDLE; otherwise go to RD.
REQ-023 fifo_rd_req SHALL never be asserted while fifo_empty=1; if fifo_empty=1 on entry to RD, no strobe is issued and the block goes to IDLE.
REQ-024 Timeout counter: clears in IDLE when fifo_empty=1, whenever the state is not IDLE, and when fifo_usedw>=PKT_LEN; otherwise it increments, saturating at TIMEOUT_CYC-1.
REQ-025 Expiry = counter equals TIMEOUT_CYC-1.
REQ-026 Full-burst and timeout conditions true in the same cycle: treat as a full burst (count = PKT_LEN).
REQ-027 Bytes written to the FIFO during a burst SHALL NOT extend it; they are handled by later bursts.
REQ-028 Bytes SHALL be transmitted in FIFO order with no loss or duplication.
REQ-029 Best-case spacing from one tx_start to the next = UART frame time + 4 cycles (WAIT_DONE, RD, LAT, LAUNCH).

Reset
REQ-030 When rst_n=0: state = IDLE; fifo_rd_req=0, tx_start=0, tx_data=8'h00, sched_busy=0; counters = 0.
REQ-031 Reset asserted mid-burst SHALL abort immediately; the byte in flight in the UART is not tracked and no read is replayed.
REQ-032 Reset release: first state transition no earlier than the first rising clk edge with rst_n=1.

Configuration
REQ-033 Macro UART_TX_SCHED_TIMEOUT_EN defined: partial-burst flush per REQ-015 and REQ-024..REQ-026.
REQ-034 Macro undefined: timeout counter removed; only full bursts (fifo_usedw>=PKT_LEN) are sent; fewer than PKT_LEN bytes stay in the FIFO indefinitely.

Verification
REQ-035 FIFO holds 8'hA5,8'h3C,8'hFF,8'h00 (usedw=4), UART model busy 52080 cycles per byte -> four tx_start pulses carrying A5,3C,FF,00 in order, then IDLE, sched_busy=0.
REQ-036 Two bytes 8'h11,8'h22 written, TIMEOUT_EN defined -> first tx_start 52080±2 cycles after the second write; burst length 2. TIMEOUT_EN undefined -> no tx_start within 200000 cycles.
REQ-037 usedw=9 with PKT_LEN=4 -> bursts of 4, 4 and 1 (the last via timeout); 9 bytes total, order preserved.
REQ-038 rst_n pulled low during WAIT_DONE of byte 2 -> next cycle all outputs at reset values; after release the remaining bytes are sent without duplicating byte 2.
REQ-039 UART model never raises tx_busy -> WAIT_ACK exits after 4 cycles; the next byte is read only after tx_busy=0 is confirmed in WAIT_DONE.
REQ-040 Bench checks throughout: no fifo_rd_req while fifo_empty=1; tx_data stable between tx_start pulses.
